axi_write_aligner: RTL

AXI_WRITE_ALIGNER -- requirements
Module: axi_write_aligner

---
 rtl/axi_write_aligner_if.sv | 25 ++
 rtl/axi_write_aligner.sv | 101 ++++++++++
 2 files changed

// File: rtl/axi_write_aligner_if.sv
// Request and line-write signals of the write aligner.
// The slave modport is the aligner side; the master modport is the requester/line-writer side.
interface axi_write_aligner_if;
    logic         req_valid;
    logic [63:0]  req_addr;
    logic [5:0]   req_len;
    logic [511:0] req_data;
    logic         req_ready;
    logic         wvalid;
    logic [63:0]  waddr;
    logic [63:0]  wstrb;
    logic [511:0] wdata;
    logic         wready;
    logic         busy;

    modport slave (
        input  req_valid, req_addr, req_len, req_data, wready,
        output req_ready, wvalid, waddr, wstrb, wdata, busy
    );

    modport master (
        output req_valid, req_addr, req_len, req_data, wready,
        input  req_ready, wvalid, waddr, wstrb, wdata, busy
    );
endinterface

// File: rtl/axi_write_aligner.sv
// Splits one unaligned write request of up to 64 bytes into one or two
// 64-byte line writes with byte strobes.
module axi_write_aligner (
    input  logic              clk,
    input  logic              nreset,
    axi_write_aligner_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [63:0]  r_addr;
    logic [5:0]   r_len;
    logic [511:0] r_data;
    logic         r_split;

    logic [5:0]   w_req_off;
    logic [7:0]   w_req_end;
    logic         w_req_split;
    logic         w_accept;
    logic [5:0]   w_off;
    logic [6:0]   w_n;
    logic [7:0]   w_end;
    logic [63:0]  w_base;

    always_comb begin
        w_req_off   = bus.req_addr[5:0];
        w_req_end   = {2'b00, w_req_off} + {2'b00, bus.req_len} + 8'd1;
        w_req_split = (w_req_end > 8'd64);
        w_accept    = bus.req_valid && (r_state == IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_split <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_len   <= bus.req_len;
            r_data  <= bus.req_data;
            r_split <= w_req_split;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = BEAT0;
            BEAT0:   if (bus.wready) w_next = r_split ? BEAT1 : IDLE;
            BEAT1:   if (bus.wready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_off  = r_addr[5:0];
        w_n    = {1'b0, r_len} + 7'd1;
        w_end  = {2'b00, w_off} + {1'b0, w_n};
        w_base = {r_addr[63:6], 6'b0};
    end

    // Beat 1 is only reachable when off > 0, so the 512-8*off shift never reaches 512.
    always_comb begin
        bus.wvalid = 1'b0;
        bus.waddr  = '0;
        bus.wstrb  = '0;
        bus.wdata  = '0;
        case (r_state)
            BEAT0: begin
                bus.wvalid = 1'b1;
                bus.waddr  = w_base;
                bus.wstrb  = ({64{1'b1}} >> (7'd64 - w_n)) << w_off;
                bus.wdata  = r_data << {w_off, 3'b000};
            end
            BEAT1: begin
                bus.wvalid = 1'b1;
                bus.waddr  = w_base + 64'd64;
                bus.wstrb  = {64{1'b1}} >> (8'd128 - w_end);
                bus.wdata  = r_data >> (10'd512 - {1'b0, w_off, 3'b000});
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (r_state == IDLE) && nreset;
    assign bus.busy      = (r_state != IDLE);
endmodule
